// File: rtl/triangle_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_word_serializer
//  Description : Transmit side of the triangle word stream. Accepts one
//                Triangle3D + Color per valid/ready handshake, packs it into
//                six 32-bit data words and emits them into the outbound word
//                FIFO. Each frame is one FRAME_START word, 6 data words per
//                triangle (triangles back-to-back), then one FRAME_END word.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   1    system clock
//    rst              in   1    synchronous reset, active-high
//    tri_valid        in   1    triangle + color presented
//    tri_last         in   1    presented triangle closes the frame
//    tri_vertices_in  in   144  {p.x,p.y,p.z,q.x,q.y,q.z,r.x,r.y,r.z}, 16b each
//    tri_color_in     in   24   {r,g,b}, 8b each
//    tri_ready        out  1    triangle accepted when tri_valid & tri_ready
//    word_ready       in   1    downstream buffer can take a word
//    word_out         out  32   stream word
//    word_valid       out  1    word_out valid; transfer = valid & ready
//    frame_open       out  1    FRAME_START sent, FRAME_END not yet sent
//    collision        out  1    1-cycle pulse: captured w0 equals FRAME_END
// ============================================================================
module triangle_word_serializer #(
  parameter logic [31:0] FRAME_START = 32'd0,
  parameter logic [31:0] FRAME_END   = 32'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tri_valid,
  input  logic         tri_last,
  input  logic [143:0] tri_vertices_in,
  input  logic [23:0]  tri_color_in,
  output logic         tri_ready,
  input  logic         word_ready,
  output logic [31:0]  word_out,
  output logic         word_valid,
  output logic         frame_open,
  output logic         collision
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  localparam logic [2:0] C_LAST_IDX = 3'd5;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [2:0]  r_idx;
  logic        r_last;
  logic        r_collision;
  logic [31:0] r_w0, r_w1, r_w2, r_w3, r_w4, r_w5;

  // --------------------------------------------------------------------------
  // Field extraction from the input triangle and color
  // --------------------------------------------------------------------------
  logic [15:0] w_px, w_py, w_pz;
  logic [15:0] w_qx, w_qy, w_qz;
  logic [15:0] w_rx, w_ry, w_rz;
  logic [7:0]  w_cr, w_cg, w_cb;

  assign w_px = tri_vertices_in[143:128];
  assign w_py = tri_vertices_in[127:112];
  assign w_pz = tri_vertices_in[111:96];
  assign w_qx = tri_vertices_in[95:80];
  assign w_qy = tri_vertices_in[79:64];
  assign w_qz = tri_vertices_in[63:48];
  assign w_rx = tri_vertices_in[47:32];
  assign w_ry = tri_vertices_in[31:16];
  assign w_rz = tri_vertices_in[15:0];

  assign w_cr = tri_color_in[23:16];
  assign w_cg = tri_color_in[15:8];
  assign w_cb = tri_color_in[7:0];

  // --------------------------------------------------------------------------
  // Packed data words, computed from the live inputs and captured on accept
  // --------------------------------------------------------------------------
  logic [31:0] w_pack0, w_pack1, w_pack2, w_pack3, w_pack4, w_pack5;

  assign w_pack0 = {w_py, w_px};
  assign w_pack1 = {w_qx, w_pz};
  assign w_pack2 = {w_qz, w_qy};
  assign w_pack3 = {w_ry, w_rx};
  assign w_pack4 = {w_cg, w_cr, w_rz};
  assign w_pack5 = {24'h00_0000, w_cb};

  // --------------------------------------------------------------------------
  // Handshakes. tri_ready and word_valid are decoded from disjoint state
  // sets, so an accept and a word transfer can never happen in one cycle.
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_xfer;

  assign tri_ready  = (r_state == S_IDLE) || (r_state == S_GAP);
  assign word_valid = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_END);
  assign w_accept   = tri_valid && tri_ready;
  assign w_xfer     = word_valid && word_ready;

  // The frame is open once FRAME_START has left and stays open until the
  // FRAME_END word has been transferred.
  assign frame_open = (r_state == S_DATA) || (r_state == S_GAP) ||
                      (r_state == S_END);
  assign collision  = r_collision;

  // --------------------------------------------------------------------------
  // Output word mux. Driven purely from registered state so that it is
  // stable under backpressure.
  // --------------------------------------------------------------------------
  logic [31:0] w_data_word;

  always_comb begin
    w_data_word = r_w0;
    case (r_idx)
      3'd0:    w_data_word = r_w0;
      3'd1:    w_data_word = r_w1;
      3'd2:    w_data_word = r_w2;
      3'd3:    w_data_word = r_w3;
      3'd4:    w_data_word = r_w4;
      3'd5:    w_data_word = r_w5;
      default: w_data_word = r_w0;
    endcase
  end

  always_comb begin
    word_out = 32'h0000_0000;
    case (r_state)
      S_START: word_out = FRAME_START;
      S_DATA:  word_out = w_data_word;
      S_END:   word_out = FRAME_END;
      default: word_out = 32'h0000_0000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w0        <= 32'h0000_0000;
      r_w1        <= 32'h0000_0000;
      r_w2        <= 32'h0000_0000;
      r_w3        <= 32'h0000_0000;
      r_w4        <= 32'h0000_0000;
      r_w5        <= 32'h0000_0000;
      r_last      <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      // Diagnostic only: a w0 equal to FRAME_END would be misread by the
      // receiver as the end of frame; the word is still sent unmodified.
      r_collision <= w_accept && (w_pack0 == FRAME_END);
      if (w_accept) begin
        r_w0   <= w_pack0;
        r_w1   <= w_pack1;
        r_w2   <= w_pack2;
        r_w3   <= w_pack3;
        r_w4   <= w_pack4;
        r_w5   <= w_pack5;
        r_last <= tri_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_START;
            r_idx   <= 3'd0;
          end
        end

        S_START: begin
          if (w_xfer) begin
            r_state <= S_DATA;
            r_idx   <= 3'd0;
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            if (r_idx == C_LAST_IDX) begin
              r_idx   <= 3'd0;
              r_state <= r_last ? S_END : S_GAP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end

        // Between triangles of one frame: the next triangle continues the
        // frame directly with its data words, no new FRAME_START.
        S_GAP: begin
          if (w_accept) begin
            r_state <= S_DATA;
            r_idx   <= 3'd0;
          end
        end

        S_END: begin
          if (w_xfer) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triangle_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_triangle_word_serializer
//  Description : Directed self-checking bench for triangle_word_serializer.
//                Expected words are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_word_serializer;

  logic         clk;
  logic         rst;
  logic         tri_valid;
  logic         tri_last;
  logic [143:0] tri_vertices_in;
  logic [23:0]  tri_color_in;
  logic         tri_ready;
  logic         word_ready;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         frame_open;
  logic         collision;

  int n_tests;
  int n_fail;

  logic [31:0] ev [0:15];

  triangle_word_serializer u_dut (
    .clk             (clk),
    .rst             (rst),
    .tri_valid       (tri_valid),
    .tri_last        (tri_last),
    .tri_vertices_in (tri_vertices_in),
    .tri_color_in    (tri_color_in),
    .tri_ready       (tri_ready),
    .word_ready      (word_ready),
    .word_out        (word_out),
    .word_valid      (word_valid),
    .frame_open      (frame_open),
    .collision       (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples live 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] mk_tri(
    input logic [15:0] px, py, pz, qx, qy, qz, rx, ry, rz);
    return {px, py, pz, qx, qy, qz, rx, ry, rz};
  endfunction

  // Present a triangle and wait (bounded) for it to be accepted. With
  // hold=1 tri_valid is left asserted after the accept edge.
  task automatic send_tri(input logic [143:0] v, input logic [23:0] c,
                          input logic last, input logic hold);
    tri_vertices_in = v;
    tri_color_in    = c;
    tri_last        = last;
    tri_valid       = 1'b1;
    for (int k = 0; k < 20 && !tri_ready; k++) step();
    check("accept_wait", {31'd0, tri_ready}, 32'd1);
    step();
    if (!hold) tri_valid = 1'b0;
  endtask

  // Check n consecutive words from ev[]. frame_open is expected from index
  // open_from on; collision is expected in cycle 0 only when col_first=1;
  // stall_at >= 0 holds word_ready low for 3 cycles at that index.
  task automatic run_stream(input int n, input int open_from,
                            input logic col_first, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        word_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check("stall_valid", {31'd0, word_valid}, 32'd1);
          check("stall_word", word_out, ev[i]);
          step();
        end
        word_ready = 1'b1;
      end
      check($sformatf("valid[%0d]", i), {31'd0, word_valid}, 32'd1);
      check($sformatf("word[%0d]", i), word_out, ev[i]);
      check($sformatf("ready_lo[%0d]", i), {31'd0, tri_ready}, 32'd0);
      check($sformatf("open[%0d]", i), {31'd0, frame_open},
            {31'd0, (i >= open_from)});
      check($sformatf("coll[%0d]", i), {31'd0, collision},
            {31'd0, (col_first && i == 0)});
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, tri_ready}, 32'd1);
    check({tag, "_open"},  {31'd0, frame_open}, 32'd0);
  endtask

  task automatic load_a_full();   // START + triangle A + END
    ev[0] = 32'h0000_0000; ev[1] = 32'h0002_0001; ev[2] = 32'h0004_0003;
    ev[3] = 32'h0006_0005; ev[4] = 32'h0008_0007; ev[5] = 32'hB0A0_0009;
    ev[6] = 32'h0000_00C0; ev[7] = 32'h0000_0001;
  endtask

  task automatic load_b_tail();   // triangle B + END
    ev[0] = 32'h2222_1111; ev[1] = 32'h4444_3333; ev[2] = 32'h6666_5555;
    ev[3] = 32'h8888_7777; ev[4] = 32'h2211_9999; ev[5] = 32'h0000_0033;
    ev[6] = 32'h0000_0001;
  endtask

  logic [143:0] tri_a, tri_b, tri_c;
  logic [23:0]  col_a, col_b;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst             = 1'b1;
    tri_valid       = 1'b0;
    tri_last        = 1'b0;
    tri_vertices_in = '0;
    tri_color_in    = '0;
    word_ready      = 1'b1;

    tri_a = mk_tri(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9);
    col_a = 24'hA0B0C0;
    tri_b = mk_tri(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                   16'h6666, 16'h7777, 16'h8888, 16'h9999);
    col_b = 24'h112233;
    tri_c = mk_tri(16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);

    step(); step();
    // Reset state
    check_idle("rst");
    check("rst_word", word_out, 32'h0);
    check("rst_coll", {31'd0, collision}, 32'd0);
    rst = 1'b0;
    step();

    // 1. Single triangle, last=1, zero stall
    load_a_full();
    send_tri(tri_a, col_a, 1'b1, 1'b0);
    run_stream(8, 1, 1'b0, -1);
    check_idle("t1_end");

    // 2. Two triangles, second presented during GAP
    load_a_full();
    send_tri(tri_a, col_a, 1'b0, 1'b0);
    run_stream(7, 1, 1'b0, -1);
    for (int g = 0; g < 2; g++) begin
      check("gap_valid", {31'd0, word_valid}, 32'd0);
      check("gap_ready", {31'd0, tri_ready}, 32'd1);
      check("gap_open", {31'd0, frame_open}, 32'd1);
      step();
    end
    load_b_tail();
    send_tri(tri_b, col_b, 1'b1, 1'b0);
    run_stream(7, 0, 1'b0, -1);
    check_idle("t2_end");

    // 3. Backpressure at idx=2 (stream index 3)
    load_a_full();
    send_tri(tri_a, col_a, 1'b1, 1'b0);
    run_stream(8, 1, 1'b0, 3);
    check_idle("t3_end");

    // 4. Collision: w0 == FRAME_END
    ev[0] = 32'h0000_0000; ev[1] = 32'h0000_0001;
    for (int i = 2; i < 7; i++) ev[i] = 32'h0000_0000;
    ev[7] = 32'h0000_0001;
    send_tri(tri_c, 24'h000000, 1'b1, 1'b0);
    run_stream(8, 1, 1'b1, -1);
    check_idle("t4_end");
    check("t4_coll_after", {31'd0, collision}, 32'd0);

    // 5. Reset while in DATA idx=3
    load_a_full();
    send_tri(tri_a, col_a, 1'b1, 1'b0);
    run_stream(4, 1, 1'b0, -1);
    check("t5_pre_word", word_out, 32'h0008_0007);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("t5_rst");
    step();
    send_tri(tri_a, col_a, 1'b1, 1'b0);
    run_stream(8, 1, 1'b0, -1);
    check_idle("t5_end");

    // 6. tri_valid held through START/DATA: second triangle taken in GAP
    load_a_full();
    send_tri(tri_a, col_a, 1'b0, 1'b1);
    tri_vertices_in = tri_b;
    tri_color_in    = col_b;
    tri_last        = 1'b1;
    run_stream(7, 1, 1'b0, -1);
    check("t6_gap_ready", {31'd0, tri_ready}, 32'd1);
    check("t6_gap_valid", {31'd0, word_valid}, 32'd0);
    step();
    tri_valid = 1'b0;
    load_b_tail();
    run_stream(7, 0, 1'b0, -1);
    check_idle("t6_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
